cache_stats: RTL and testbench
==============================

Name: cache_stats

Overview:
- Performance monitor directly downstream of the direct-mapped cache (16 blocks, 16 B lines, 11-bit address, index = addr[7:4]).
- Snoops the same read/addr the cache samples, plus the cache's registered hit output. Classifies every access as hit, compulsory miss or conflict miss.
- Maintains saturating event counters, miss-run tracking and a fixed-size hit-rate window.
- Observation only: never stalls or drives the cache.

Parameters:
CNT_W, 16, width of all event counters and run-length registers
WINDOW, 16, accesses per hit-rate window (power of two, >=2)
WIN_W, 5, width of win_hits (must hold WINDOW, i.e. log2(WINDOW)+1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset; tied to the inverse of the cache reset so shadow state tracks cache valid bits
read  in  1  read strobe, same signal driving the cache
addr  in  11  access address, same signal driving the cache
hit  in  1  cache hit output; valid the cycle after the read is sampled
clear  in  1  synchronous counter clear, does not touch shadow valid bits
access_cnt  out  CNT_W  retired accesses
hit_cnt  out  CNT_W  hits
miss_cnt  out  CNT_W  misses
comp_miss_cnt  out  CNT_W  misses to never-filled index
conf_miss_cnt  out  CNT_W  misses to already-filled index
cur_miss_run  out  CNT_W  current consecutive-miss streak
max_miss_run  out  CNT_W  longest streak since reset/clear
win_hits  out  WIN_W  hits in last completed window
win_valid  out  1  one-cycle pulse when a window completes

Behaviour:
- Reset (rst_n=0 at edge): all outputs 0; pending stage empty; shadow_valid[15:0] = 0; window count = 0. An access pending at reset is dropped.
- Stage 1 (edge N, read=1): pend <= 1, pend_idx <= addr[7:4]. On that edge the cache updates hit. read=0 gives pend <= 0.
- Stage 2 (edge N+1, pend=1): the access retires using hit. Counters reflect an access exactly one edge after it was sampled.
- Back-to-back reads retire one per cycle with no bubbles.
- On retire:
  - access_cnt+1.
  - Hit: hit_cnt+1, cur_miss_run <= 0.
  - Miss: miss_cnt+1, cur_miss_run+1, max_miss_run <= max(max_miss_run, new cur_miss_run).
  - Miss with shadow_valid[pend_idx]=0: comp_miss_cnt+1. Otherwise conf_miss_cnt+1.
  - Any miss sets shadow_valid[pend_idx] <= 1, mirroring cache fill on miss.
- Window logic:
  - Each retire increments win_acc and adds hit to win_acc_hits.
  - When win_acc reaches WINDOW: win_hits <= accumulated hits including the current one; win_valid = 1 for that one cycle; accumulators restart at 0.
  - win_valid is 0 in all other cycles.
- Saturation: every counter and run register holds at 2^CNT_W-1; each saturates independently. Invariants hit+miss=access and comp+conf=miss hold only while no counter is saturated.
- clear=1 at edge:
  - Zeroes all counters, runs, win_hits, window accumulators and win_valid.
  - Takes priority over a simultaneous retire; that access is not counted.
  - pend and shadow_valid are unaffected. A read sampled the same edge still retires next edge.
- rst_n dominates clear.
- X on hit while pend=0 is ignored.

Test Plan:
1. Reset, then back-to-back reads 0x000, 0x000, 0x100, 0x000 -> access 4, hit 1, miss 3, comp 1, conf 2, cur_miss_run 2, max_miss_run 2.
2. Read 0x020, then 3 idle cycles, then read 0x020 -> access_cnt changes only on the edge after each read. Final state: hit 1, miss 1 (comp), cur_miss_run 0.
3. WINDOW=16: 16 consecutive reads of 0x010 -> win_valid high exactly one cycle, on the 16th retire edge, with win_hits=15. 16 more reads of 0x010 -> win_hits=16.
4. CNT_W=4: read 0x030 once, then 20 hits -> hit_cnt=15 held, access_cnt=15, miss_cnt=1, no wrap.
5. Fill index 2 (read 0x020), pulse clear coincident with the retire of a read of 0x120 -> all counters 0. Then read 0x220 -> conf_miss_cnt=1, comp_miss_cnt=0 (shadow preserved).
6. After step 5, rst_n=0 one cycle, then read 0x220 -> comp_miss_cnt=1, conf_miss_cnt=0. A read sampled in the reset cycle is not counted.

Source files
------------

// File: rtl/cache_stats.sv
// Performance monitor for the 16-block direct-mapped cache. It classifies each retired
// access as a hit, compulsory miss or conflict miss, and keeps saturating counters plus a hit-rate window.
module cache_stats #(
    parameter int CNT_W  = 16,
    parameter int WINDOW = 16,
    parameter int WIN_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read,
    input  logic [10:0]      addr,
    input  logic             hit,
    input  logic             clear,
    output logic [CNT_W-1:0] access_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] comp_miss_cnt,
    output logic [CNT_W-1:0] conf_miss_cnt,
    output logic [CNT_W-1:0] cur_miss_run,
    output logic [CNT_W-1:0] max_miss_run,
    output logic [WIN_W-1:0] win_hits,
    output logic             win_valid
);

    logic             pend_q, pend_d;
    logic [3:0]       pend_idx_q, pend_idx_d;
    logic [15:0]      shadow_valid_q, shadow_valid_d;
    logic [CNT_W-1:0] access_cnt_q, access_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] comp_miss_cnt_q, comp_miss_cnt_d;
    logic [CNT_W-1:0] conf_miss_cnt_q, conf_miss_cnt_d;
    logic [CNT_W-1:0] cur_miss_run_q, cur_miss_run_d;
    logic [CNT_W-1:0] max_miss_run_q, max_miss_run_d;
    logic [WIN_W-1:0] win_acc_q, win_acc_d;
    logic [WIN_W-1:0] win_acc_hits_q, win_acc_hits_d;
    logic [WIN_W-1:0] win_hits_q, win_hits_d;
    logic             win_valid_q, win_valid_d;

    logic             retire;
    logic [CNT_W-1:0] run_inc;
    logic [WIN_W-1:0] win_acc_nx, win_acc_hits_nx;

    // Tag and offset bits play no part in classification; only the index is tracked.
    logic unused_addr;
    assign unused_addr = ^{addr[10:8], addr[3:0]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign retire = pend_q;

    always_comb begin
        pend_d          = read;
        pend_idx_d      = addr[7:4];
        shadow_valid_d  = shadow_valid_q;
        access_cnt_d    = access_cnt_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        comp_miss_cnt_d = comp_miss_cnt_q;
        conf_miss_cnt_d = conf_miss_cnt_q;
        cur_miss_run_d  = cur_miss_run_q;
        max_miss_run_d  = max_miss_run_q;
        win_acc_d       = win_acc_q;
        win_acc_hits_d  = win_acc_hits_q;
        win_hits_d      = win_hits_q;
        win_valid_d     = 1'b0;
        run_inc         = sat_inc(cur_miss_run_q);
        win_acc_nx      = win_acc_q + WIN_W'(1);
        win_acc_hits_nx = win_acc_hits_q + {{(WIN_W-1){1'b0}}, hit};

        // The cache fills on every miss, even one whose count is discarded by clear.
        if (retire && !hit)
            shadow_valid_d[pend_idx_q] = 1'b1;

        if (clear) begin
            access_cnt_d    = '0;
            hit_cnt_d       = '0;
            miss_cnt_d      = '0;
            comp_miss_cnt_d = '0;
            conf_miss_cnt_d = '0;
            cur_miss_run_d  = '0;
            max_miss_run_d  = '0;
            win_acc_d       = '0;
            win_acc_hits_d  = '0;
            win_hits_d      = '0;
        end else if (retire) begin
            access_cnt_d = sat_inc(access_cnt_q);
            if (hit) begin
                hit_cnt_d      = sat_inc(hit_cnt_q);
                cur_miss_run_d = '0;
            end else begin
                miss_cnt_d     = sat_inc(miss_cnt_q);
                cur_miss_run_d = run_inc;
                max_miss_run_d = (run_inc > max_miss_run_q) ? run_inc : max_miss_run_q;
                if (shadow_valid_q[pend_idx_q])
                    conf_miss_cnt_d = sat_inc(conf_miss_cnt_q);
                else
                    comp_miss_cnt_d = sat_inc(comp_miss_cnt_q);
            end
            if (win_acc_nx == WIN_W'(WINDOW)) begin
                win_hits_d     = win_acc_hits_nx;
                win_valid_d    = 1'b1;
                win_acc_d      = '0;
                win_acc_hits_d = '0;
            end else begin
                win_acc_d      = win_acc_nx;
                win_acc_hits_d = win_acc_hits_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q          <= 1'b0;
            pend_idx_q      <= '0;
            shadow_valid_q  <= '0;
            access_cnt_q    <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
            comp_miss_cnt_q <= '0;
            conf_miss_cnt_q <= '0;
            cur_miss_run_q  <= '0;
            max_miss_run_q  <= '0;
            win_acc_q       <= '0;
            win_acc_hits_q  <= '0;
            win_hits_q      <= '0;
            win_valid_q     <= 1'b0;
        end else begin
            pend_q          <= pend_d;
            pend_idx_q      <= pend_idx_d;
            shadow_valid_q  <= shadow_valid_d;
            access_cnt_q    <= access_cnt_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            comp_miss_cnt_q <= comp_miss_cnt_d;
            conf_miss_cnt_q <= conf_miss_cnt_d;
            cur_miss_run_q  <= cur_miss_run_d;
            max_miss_run_q  <= max_miss_run_d;
            win_acc_q       <= win_acc_d;
            win_acc_hits_q  <= win_acc_hits_d;
            win_hits_q      <= win_hits_d;
            win_valid_q     <= win_valid_d;
        end
    end

    assign access_cnt    = access_cnt_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;
    assign comp_miss_cnt = comp_miss_cnt_q;
    assign conf_miss_cnt = conf_miss_cnt_q;
    assign cur_miss_run  = cur_miss_run_q;
    assign max_miss_run  = max_miss_run_q;
    assign win_hits      = win_hits_q;
    assign win_valid     = win_valid_q;

endmodule

// File: tb/tb_cache_stats.sv
// Bench for cache_stats: two instances (16-bit and 4-bit counters) share one stimulus stream.
// A behavioural cache plus statistics model supplies hit and every expected value.
module tb_cache_stats;
    localparam int WINDOW = 16;
    localparam int WIN_W  = 5;

    logic        clk, rst_n, read, hit, clear;
    logic [10:0] addr;

    logic [15:0] a16, h16, m16, cp16, cf16, cr16, mr16;
    logic [3:0]  a4, h4, m4, cp4, cf4, cr4, mr4;
    logic [WIN_W-1:0] wh16, wh4;
    logic        wv16, wv4;

    cache_stats #(.CNT_W(16), .WINDOW(WINDOW), .WIN_W(WIN_W)) dut16 (
        .clk(clk), .rst_n(rst_n), .read(read), .addr(addr), .hit(hit), .clear(clear),
        .access_cnt(a16), .hit_cnt(h16), .miss_cnt(m16), .comp_miss_cnt(cp16),
        .conf_miss_cnt(cf16), .cur_miss_run(cr16), .max_miss_run(mr16),
        .win_hits(wh16), .win_valid(wv16));

    cache_stats #(.CNT_W(4), .WINDOW(WINDOW), .WIN_W(WIN_W)) dut4 (
        .clk(clk), .rst_n(rst_n), .read(read), .addr(addr), .hit(hit), .clear(clear),
        .access_cnt(a4), .hit_cnt(h4), .miss_cnt(m4), .comp_miss_cnt(cp4),
        .conf_miss_cnt(cf4), .cur_miss_run(cr4), .max_miss_run(mr4),
        .win_hits(wh4), .win_valid(wv4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Model state: index 0 tracks the 16-bit instance, index 1 the 4-bit one.
    int  lim[2] = '{65535, 15};
    int  m_acc[2], m_hit[2], m_miss[2], m_comp[2], m_conf[2], m_cur[2], m_max[2];
    int  m_wacc, m_whits, m_win_hits;
    bit  m_win_valid;
    bit  m_pend, next_hit;
    int  m_pidx;
    bit  shadow[16];
    bit  cvalid[16];
    int  ctag[16];

    function automatic int sat(input int v, input int l);
        return (v > l) ? l : v;
    endfunction

    task automatic model_step(input bit r, input logic [10:0] a, input bit c, input bit rn);
        bit h;
        int idx;
        h = hit;
        idx = int'(a[7:4]);
        if (!rn) begin
            for (int d = 0; d < 2; d++) begin
                m_acc[d] = 0; m_hit[d] = 0; m_miss[d] = 0; m_comp[d] = 0;
                m_conf[d] = 0; m_cur[d] = 0; m_max[d] = 0;
            end
            m_wacc = 0; m_whits = 0; m_win_hits = 0; m_win_valid = 0; m_pend = 0;
            for (int i = 0; i < 16; i++) begin shadow[i] = 0; cvalid[i] = 0; end
            return;
        end
        for (int d = 0; d < 2; d++) begin
            if (c) begin
                m_acc[d] = 0; m_hit[d] = 0; m_miss[d] = 0; m_comp[d] = 0;
                m_conf[d] = 0; m_cur[d] = 0; m_max[d] = 0;
            end else if (m_pend) begin
                m_acc[d] = sat(m_acc[d] + 1, lim[d]);
                if (h) begin
                    m_hit[d] = sat(m_hit[d] + 1, lim[d]);
                    m_cur[d] = 0;
                end else begin
                    m_miss[d] = sat(m_miss[d] + 1, lim[d]);
                    m_cur[d]  = sat(m_cur[d] + 1, lim[d]);
                    if (m_cur[d] > m_max[d]) m_max[d] = m_cur[d];
                    if (shadow[m_pidx]) m_conf[d] = sat(m_conf[d] + 1, lim[d]);
                    else                m_comp[d] = sat(m_comp[d] + 1, lim[d]);
                end
            end
        end
        if (m_pend && !h) shadow[m_pidx] = 1;
        m_win_valid = 0;
        if (c) begin
            m_wacc = 0; m_whits = 0; m_win_hits = 0;
        end else if (m_pend) begin
            m_wacc++;
            m_whits += int'(h);
            if (m_wacc == WINDOW) begin
                m_win_hits = m_whits; m_win_valid = 1; m_wacc = 0; m_whits = 0;
            end
        end
        m_pend = r;
        m_pidx = idx;
        if (r) begin
            next_hit = cvalid[idx] && (ctag[idx] == int'(a[10:8]));
            if (!next_hit) begin cvalid[idx] = 1; ctag[idx] = int'(a[10:8]); end
        end
    endtask

    task automatic check_all();
        chk("acc16", int'(a16), m_acc[0]);   chk("acc4", int'(a4), m_acc[1]);
        chk("hit16", int'(h16), m_hit[0]);   chk("hit4", int'(h4), m_hit[1]);
        chk("miss16", int'(m16), m_miss[0]); chk("miss4", int'(m4), m_miss[1]);
        chk("comp16", int'(cp16), m_comp[0]); chk("comp4", int'(cp4), m_comp[1]);
        chk("conf16", int'(cf16), m_conf[0]); chk("conf4", int'(cf4), m_conf[1]);
        chk("cur16", int'(cr16), m_cur[0]);  chk("cur4", int'(cr4), m_cur[1]);
        chk("max16", int'(mr16), m_max[0]);  chk("max4", int'(mr4), m_max[1]);
        chk("winh16", int'(wh16), m_win_hits); chk("winh4", int'(wh4), m_win_hits);
        chk("winv16", int'(wv16), int'(m_win_valid)); chk("winv4", int'(wv4), int'(m_win_valid));
    endtask

    // One clock: drive inputs just after the previous edge, step model at the edge, compare.
    task automatic cycle(input bit r, input logic [10:0] a, input bit c, input bit rn);
        hit   = m_pend ? next_hit : 1'($urandom);
        read  = r;
        addr  = a;
        clear = c;
        rst_n = rn;
        @(posedge clk);
        #1;
        model_step(r, a, c, rn);
        check_all();
    endtask

    task automatic do_reset();
        cycle(1'b0, 11'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [10:0] a);
        cycle(1'b1, a, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, 11'h0, 1'b0, 1'b1);
    endtask

    int wv_cnt;

    initial begin
        read = 0; addr = 0; clear = 0; rst_n = 0; hit = 0;
        m_pend = 0; next_hit = 0;
        do_reset();
        do_reset();
        chk("rst_acc", int'(a16), 0);
        chk("rst_winv", int'(wv16), 0);

        // Back-to-back reads: compulsory then conflict misses.
        rd(11'h000); rd(11'h000); rd(11'h100); rd(11'h000); idle();
        chk("t1_acc", int'(a16), 4);   chk("t1_hit", int'(h16), 1);
        chk("t1_miss", int'(m16), 3);  chk("t1_comp", int'(cp16), 1);
        chk("t1_conf", int'(cf16), 2); chk("t1_cur", int'(cr16), 2);
        chk("t1_max", int'(mr16), 2);

        // Retire latency with gaps.
        do_reset();
        rd(11'h020);
        chk("t2_acc_pre", int'(a16), 0);
        idle();
        chk("t2_acc_one", int'(a16), 1);
        idle(); idle(); rd(11'h020);
        chk("t2_acc_hold", int'(a16), 1);
        idle();
        chk("t2_hit", int'(h16), 1); chk("t2_miss", int'(m16), 1);
        chk("t2_comp", int'(cp16), 1); chk("t2_cur", int'(cr16), 0);

        // Hit-rate window.
        do_reset();
        wv_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            rd(11'h010);
            if (wv16) wv_cnt++;
            if (i == 16) begin
                chk("t3_wv_first", int'(wv16), 1);
                chk("t3_wh_first", int'(wh16), 15);
            end
        end
        idle();
        if (wv16) wv_cnt++;
        chk("t3_wv_second", int'(wv16), 1);
        chk("t3_wh_second", int'(wh16), 16);
        chk("t3_wv_count", wv_cnt, 2);

        // Saturation on the 4-bit instance.
        do_reset();
        rd(11'h030);
        for (int i = 0; i < 20; i++) rd(11'h030);
        idle();
        chk("t4_hit4", int'(h4), 15); chk("t4_acc4", int'(a4), 15);
        chk("t4_miss4", int'(m4), 1); chk("t4_acc16", int'(a16), 21);

        // Clear drops the coincident retire but keeps shadow state.
        do_reset();
        rd(11'h020); idle();
        rd(11'h120);
        cycle(1'b0, 11'h0, 1'b1, 1'b1);
        chk("t5_acc_clr", int'(a16), 0); chk("t5_miss_clr", int'(m16), 0);
        chk("t5_comp_clr", int'(cp16), 0); chk("t5_max_clr", int'(mr16), 0);
        rd(11'h220); idle();
        chk("t5_conf", int'(cf16), 1); chk("t5_comp", int'(cp16), 0);

        // Reset wipes shadow state and drops a read sampled during reset.
        cycle(1'b1, 11'h220, 1'b0, 1'b0);
        idle();
        chk("t6_acc_drop", int'(a16), 0);
        rd(11'h220); idle();
        chk("t6_comp", int'(cp16), 1); chk("t6_conf", int'(cf16), 0);

        // Randomized traffic with occasional clear and reset.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [10:0] a;
            bit r, c, rn;
            a  = {3'($urandom_range(0, 3)), 4'($urandom), 4'($urandom)};
            r  = ($urandom_range(0, 9) < 8);
            c  = ($urandom_range(0, 199) == 0);
            rn = ($urandom_range(0, 499) != 0);
            cycle(r, a, c, rn);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
